// File: rtl/parity_sweep_pkg.sv
// rtl/parity_sweep_pkg.sv - shared types, defaults and golden parity function for the parity sweep controller
package parity_sweep_pkg;

  localparam int N_IN_DEFAULT   = 3;
  localparam int SETTLE_DEFAULT = 2;
  localparam int NUM_VEC        = 2 ** N_IN_DEFAULT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Zero-extending the vector to 32 bits leaves its parity unchanged.
  function automatic logic exp_parity(input logic [31:0] vec, input logic odd_mode);
    return odd_mode ? ^vec : ~^vec;
  endfunction

endpackage

// File: rtl/parity_ref_model.sv
// rtl/parity_ref_model.sv - combinational golden model of the 3-input parity/odd-checker gate
module parity_ref_model
  import parity_sweep_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT
) (
  input  logic [N_IN-1:0] vec,
  input  logic            odd_mode,
  output logic            exp_w
);

  always_comb begin
    exp_w = exp_parity(32'(vec), odd_mode);
  end

endmodule

// File: rtl/parity_sweep_ctrl.sv
// rtl/parity_sweep_ctrl.sv - sweeps every input vector through the gate, settles, samples and scores against parity
module parity_sweep_ctrl
  import parity_sweep_pkg::*;
#(
  parameter int N_IN   = N_IN_DEFAULT,
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            odd_mode,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_w,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam int                CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]   VEC_LAST = '1;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              odd_q, odd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     err_cnt_q, err_cnt_d;
  logic [N_IN-1:0]   ffv_q, ffv_d;
  logic              ffvalid_q, ffvalid_d;
  logic              exp_w;

  parity_ref_model #(.N_IN(N_IN)) u_ref (
    .vec      (vec_q),
    .odd_mode (odd_q),
    .exp_w    (exp_w)
  );

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    odd_d     = odd_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_cnt_d = err_cnt_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;

    case (state_q)
      IDLE, DONE: begin
        if (start && !abort) begin
          odd_d     = odd_mode;
          vec_d     = '0;
          cnt_d     = '0;
          err_cnt_d = '0;
          ffvalid_d = 1'b0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        // An aborted CHECK cycle leaves the score untouched.
        if (abort) begin
          state_d = IDLE;
          vec_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else begin
          if (dut_w != exp_w) begin
            err_cnt_d = err_cnt_q + (N_IN + 1)'(1);
            if (!ffvalid_q) begin
              ffv_d     = vec_q;
              ffvalid_d = 1'b1;
            end
          end
          if (vec_q == VEC_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
          end else begin
            vec_d   = vec_q + N_IN'(1);
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      cnt_q     <= '0;
      odd_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      odd_q     <= odd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_cnt_q <= err_cnt_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  assign dut_in           = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_cnt          = err_cnt_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule
